sound_ram_server: RTL and testbench
===================================

Name: sound_ram_server

Overview:
- Responder (server) end of the sdram_port_if client protocol for the 64 KB IIgs sound RAM window.
- Services two clients with an internal 16K x 32-bit memory:
  - Client A: GLU, writes (reads allowed).
  - Client B: DOC5503 wavetable fetch, reads only.
- Stands in place of the SDRAM controller port for the sound window on builds where the sound RAM lives in block RAM.
- Returns one-cycle ready pulses with read data, as the clients expect.

Parameters:
- ADDR_WIDTH, 21: client word-address width.
- WINDOW_BASE, 7'b0000100: required value of addr[ADDR_WIDTH-1:14]; this is the sound RAM window.
- RD_LATENCY, 1: memory read pipeline depth in cycles, 1..4.

Ports:
- clk_i  in  1  logic clock.
- reset_i  in  1  asynchronous, active-high reset.
- a_rd_i  in  1  client A read request, single-cycle pulse.
- a_wr_i  in  1  client A write request, single-cycle pulse.
- a_addr_i  in  ADDR_WIDTH  client A word address.
- a_byte_en_i  in  4  client A byte enables (write only).
- a_data_i  in  32  client A write data.
- a_ready_o  out  1  client A completion pulse.
- a_q_o  out  32  client A read data; valid while a_ready_o is high.
- b_rd_i  in  1  client B read request pulse.
- b_addr_i  in  ADDR_WIDTH  client B word address.
- b_ready_o  out  1  client B completion pulse.
- b_q_o  out  32  client B read data.
- overrun_o  out  2  sticky overrun flags, {B, A}.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; pending flags clear; a_ready_o=b_ready_o=0; a_q_o=b_q_o=0; overrun_o=0; round-robin pointer=A.
  - Memory contents are NOT reset.
  - Reset mid-operation aborts the operation: no ready is issued and pending requests are discarded.
- Request capture:
  - A rd or wr pulse latches a one-deep pending slot per client: op, addr, byte_en, data.
  - a_wr_i and a_rd_i high together: treated as a write; the read is dropped.
- Overrun:
  - A new request arrives while that client's slot holds an unissued request: the new request replaces the old one and the client's overrun_o bit is set.
  - The bit stays set until reset.
- Same-cycle issue and capture:
  - A request arriving in the cycle its client's slot is issued goes into the now-free slot. This is not an overrun.
- State machine, IDLE / RD_WAIT / RESP. One operation in flight at a time.
  - IDLE with any slot pending: grant one slot, then free it.
    - Grant rule: if only one client is pending, grant it. If both are pending, grant the client the round-robin pointer names, then point the pointer at the other client.
    - Granted write: memory bytes with byte_en=1 are updated; go to RESP.
    - Granted read: go to RD_WAIT and count RD_LATENCY cycles, then go to RESP with data captured.
  - RESP lasts one cycle:
    - Assert the granted client's ready_o.
    - For reads, drive q_o with the data. q_o holds that value until that client's next read completes.
    - Return to IDLE.
- Latency, uncontended:
  - Write request in cycle N: ready in cycle N+2.
  - Read request in cycle N: ready in cycle N+2+RD_LATENCY.
  - Throughput is at most one operation every 2 cycles for writes and every 2+RD_LATENCY cycles for reads.
- Address:
  - Memory index is addr[13:0].
  - If addr[ADDR_WIDTH-1:14] != WINDOW_BASE, the memory is not accessed, the request still completes with normal latency, and read data is 32'h0.
- Client B write attempts are impossible: there is no port for them.

Optional Feature:
- Macro: SOUND_RAM_OVERRUN_CNT_EN.
- Defined: adds ports a_overrun_cnt_o and b_overrun_cnt_o, each out 8.
  - Each is a saturating count of its client's overruns: it stops at 8'hFF and clears only on reset.
  - overrun_o is unchanged.
- Undefined: the counter ports and logic are absent.

Decomposition:
- Package sound_ram_pkg holds:
  - typedef sram_req_t: op, addr[13:0], byte_en, data.
  - enum sram_state_e: IDLE, RD_WAIT, RESP.
  - localparams: MEM_WORDS=16384, OP_RD, OP_WR.
- One sub-module, sound_ram_mem: single-port 16K x 32 memory with byte-write enables and RD_LATENCY output pipeline. It infers block RAM.

Test Plan:
- Client A writes 32'hAABBCCDD to word 14'h0010 with byte_en=4'b1111, then writes 8'h11 to byte 2 with byte_en=4'b0100 and data 32'h11111111; then client B reads 14'h0010 -> b_q_o=32'hAA11CCDD, b_ready_o high exactly at request cycle+3 with RD_LATENCY=1.
- a_rd_i and b_rd_i pulse in the same cycle with pointer=A -> a_ready_o precedes b_ready_o by 3 cycles; a second simultaneous pair is served B first.
- Client B pulses twice with addresses 14'h0001 then 14'h0002 while client A's read is in flight and B's slot is still unissued -> one b_ready_o only, carrying data for 14'h0002; overrun_o=2'b10. With SOUND_RAM_OVERRUN_CNT_EN, b_overrun_cnt_o=1.
- b_addr_i has top bits != WINDOW_BASE -> b_ready_o still pulses at nominal latency, b_q_o=32'h0, and memory is unchanged.
- reset_i asserted in RD_WAIT -> no ready pulse, all outputs 0; after release, a read of a previously written word returns the pre-reset contents.
- With SOUND_RAM_OVERRUN_CNT_EN, force 300 client A overruns -> a_overrun_cnt_o saturates at 8'hFF.

Source files
------------

// File: rtl/sound_ram_pkg.sv
// Shared types and constants for the IIgs sound RAM block-RAM server.
package sound_ram_pkg;

    localparam int   MEM_WORDS = 16384;
    localparam logic OP_RD     = 1'b0;
    localparam logic OP_WR     = 1'b1;

    typedef struct packed {
        logic        op;
        logic [13:0] addr;
        logic [3:0]  byte_en;
        logic [31:0] data;
    } sram_req_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } sram_state_e;

endpackage

// File: rtl/sound_ram_mem.sv
// Single-port 16K x 32 sound RAM with byte-write enables and a RD_LATENCY-deep
// registered read path (rdata_p[0] is the block RAM output register).
module sound_ram_mem
    import sound_ram_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        en,
    input  logic        we,
    input  logic [13:0] addr,
    input  logic [3:0]  byte_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rdata_p [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_p[0] <= mem[addr];
            end
        end
        for (int k = 1; k < RD_LATENCY; k++) begin
            rdata_p[k] <= rdata_p[k-1];
        end
    end

    assign rdata = rdata_p[RD_LATENCY-1];

endmodule

// File: rtl/sound_ram_server.sv
// Block-RAM responder for the sound RAM window: arbitrates GLU (A) and DOC (B)
// requests onto one memory port. SOUND_RAM_OVERRUN_CNT_EN adds overrun counters.
module sound_ram_server
    import sound_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 21,
    parameter logic [ADDR_WIDTH-15:0] WINDOW_BASE = 7'b0000100,
    parameter int                    RD_LATENCY  = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  a_rd_i,
    input  logic                  a_wr_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [3:0]            a_byte_en_i,
    input  logic [31:0]           a_data_i,
    output logic                  a_ready_o,
    output logic [31:0]           a_q_o,
    input  logic                  b_rd_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    output logic                  b_ready_o,
    output logic [31:0]           b_q_o,
    output logic [1:0]            overrun_o
`ifdef SOUND_RAM_OVERRUN_CNT_EN
    ,
    output logic [7:0]            a_overrun_cnt_o,
    output logic [7:0]            b_overrun_cnt_o
`endif
);

    sram_state_e state, next_state;
    sram_req_t   a_slot, b_slot, sel_req;
    logic        a_pend, b_pend, a_hit, b_hit, sel_hit;
    logic        rr_b;
    logic        cur_b, cur_hit;
    logic [1:0]  wait_cnt;
    logic        grant_a, grant_b, grant, rd_done;
    logic        mem_en, mem_we;
    logic [31:0] mem_rdata;
    logic        a_new, b_new;

    assign a_new = a_rd_i | a_wr_i;
    assign b_new = b_rd_i;

    always_comb begin
        next_state = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        rd_done    = 1'b0;
        case (state)
            IDLE: begin
                if (a_pend || b_pend) begin
                    grant_a = a_pend && (!b_pend || !rr_b);
                    grant_b = !grant_a;
                end
            end
            RD_WAIT: rd_done = (wait_cnt == 2'd0);
            default: ;
        endcase
        grant   = grant_a | grant_b;
        sel_req = grant_b ? b_slot : a_slot;
        sel_hit = grant_b ? b_hit : a_hit;
        mem_en  = grant && sel_hit;
        mem_we  = (sel_req.op == OP_WR);
        case (state)
            IDLE:    if (grant) next_state = mem_we ? RESP : RD_WAIT;
            RD_WAIT: if (rd_done) next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stage p0: request slots; data fields need no reset since pend gates them.
    always_ff @(posedge clk_i) begin
        if (a_new) begin
            a_slot <= '{op: a_wr_i ? OP_WR : OP_RD, addr: a_addr_i[13:0],
                        byte_en: a_byte_en_i, data: a_data_i};
            a_hit  <= (a_addr_i[ADDR_WIDTH-1:14] == WINDOW_BASE);
        end
        if (b_new) begin
            b_slot <= '{op: OP_RD, addr: b_addr_i[13:0], byte_en: 4'h0, data: 32'h0};
            b_hit  <= (b_addr_i[ADDR_WIDTH-1:14] == WINDOW_BASE);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            a_pend    <= 1'b0;
            b_pend    <= 1'b0;
            rr_b      <= 1'b0;
            cur_b     <= 1'b0;
            cur_hit   <= 1'b0;
            wait_cnt  <= 2'd0;
            a_ready_o <= 1'b0;
            b_ready_o <= 1'b0;
            a_q_o     <= 32'h0;
            b_q_o     <= 32'h0;
            overrun_o <= 2'b00;
        end else begin
            a_ready_o <= 1'b0;
            b_ready_o <= 1'b0;
            if (grant) begin
                cur_b    <= grant_b;
                cur_hit  <= sel_hit;
                wait_cnt <= 2'(RD_LATENCY - 1);
                if (a_pend && b_pend) rr_b <= grant_a;
                if (mem_we) begin
                    a_ready_o <= grant_a;
                    b_ready_o <= grant_b;
                end
            end
            if (state == RD_WAIT && !rd_done) wait_cnt <= wait_cnt - 2'd1;
            // Stage p1: read data lands in the client's holding register with its ready.
            if (rd_done) begin
                if (cur_b) begin
                    b_ready_o <= 1'b1;
                    b_q_o     <= cur_hit ? mem_rdata : 32'h0;
                end else begin
                    a_ready_o <= 1'b1;
                    a_q_o     <= cur_hit ? mem_rdata : 32'h0;
                end
            end
            // A slot freed by this cycle's grant accepts a new request without overrun.
            if (a_new) a_pend <= 1'b1;
            else if (grant_a) a_pend <= 1'b0;
            if (b_new) b_pend <= 1'b1;
            else if (grant_b) b_pend <= 1'b0;
            if (a_new && a_pend && !grant_a) overrun_o[0] <= 1'b1;
            if (b_new && b_pend && !grant_b) overrun_o[1] <= 1'b1;
        end
    end

`ifdef SOUND_RAM_OVERRUN_CNT_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            a_overrun_cnt_o <= 8'h00;
            b_overrun_cnt_o <= 8'h00;
        end else begin
            if (a_new && a_pend && !grant_a && a_overrun_cnt_o != 8'hFF)
                a_overrun_cnt_o <= a_overrun_cnt_o + 8'h01;
            if (b_new && b_pend && !grant_b && b_overrun_cnt_o != 8'hFF)
                b_overrun_cnt_o <= b_overrun_cnt_o + 8'h01;
        end
    end
`endif

    sound_ram_mem #(
        .RD_LATENCY(RD_LATENCY)
    ) u_mem (
        .clk     (clk_i),
        .en      (mem_en),
        .we      (mem_we),
        .addr    (sel_req.addr),
        .byte_en (sel_req.byte_en),
        .wdata   (sel_req.data),
        .rdata   (mem_rdata)
    );

endmodule

// File: tb/tb_sound_ram_server.sv
// Self-checking bench for sound_ram_server: transaction-level reference model
// plus directed scenarios with literal expectations and randomized traffic.
module tb_sound_ram_server;

    localparam int        AW = 21;
    localparam int        RD_LATENCY = 1;
    localparam logic [6:0] WB = 7'b0000100;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          a_rd_i = 1'b0, a_wr_i = 1'b0, b_rd_i = 1'b0;
    logic [AW-1:0] a_addr_i = '0, b_addr_i = '0;
    logic [3:0]    a_byte_en_i = '0;
    logic [31:0]   a_data_i = '0;
    logic          a_ready_o, b_ready_o;
    logic [31:0]   a_q_o, b_q_o;
    logic [1:0]    overrun_o;
`ifdef SOUND_RAM_OVERRUN_CNT_EN
    logic [7:0]    a_overrun_cnt_o, b_overrun_cnt_o;
`endif

    always #5 clk = ~clk;

    sound_ram_server #(
        .ADDR_WIDTH(AW), .WINDOW_BASE(WB), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .a_rd_i(a_rd_i), .a_wr_i(a_wr_i), .a_addr_i(a_addr_i),
        .a_byte_en_i(a_byte_en_i), .a_data_i(a_data_i),
        .a_ready_o(a_ready_o), .a_q_o(a_q_o),
        .b_rd_i(b_rd_i), .b_addr_i(b_addr_i),
        .b_ready_o(b_ready_o), .b_q_o(b_q_o),
        .overrun_o(overrun_o)
`ifdef SOUND_RAM_OVERRUN_CNT_EN
        , .a_overrun_cnt_o(a_overrun_cnt_o), .b_overrun_cnt_o(b_overrun_cnt_o)
`endif
    );

    typedef struct {
        bit          wr;
        logic [20:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } mreq_t;

    // Reference model state
    logic [31:0] mm [16384];
    mreq_t       sa, sb;
    bit          pa = 0, pb = 0, rr = 0;
    bit          resp_valid = 0, resp_b = 0, resp_rd = 0;
    int          free_at = 0, resp_cycle = 0;
    logic [31:0] resp_data = 0, eq_a = 0, eq_b = 0;
    logic [1:0]  eovr = 0;
    int          ecnt_a = 0, ecnt_b = 0;
    int          cyc = 0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [20:0] W(input logic [13:0] i);
        return {WB, i};
    endfunction

    // Model: one operation at a time; a free server grants at the start of a cycle,
    // writes complete one cycle later, reads 1+RD_LATENCY cycles later.
    always @(posedge clk) begin
        mreq_t r;
        bit gb, hit;
        if (reset_i) begin
            pa = 0; pb = 0; rr = 0; resp_valid = 0; free_at = 0;
            eq_a = 0; eq_b = 0; eovr = 0; ecnt_a = 0; ecnt_b = 0;
        end else begin
            if (cyc >= free_at && (pa || pb)) begin
                gb = pb && (!pa || rr);
                if (pa && pb) rr = !gb;
                r = gb ? sb : sa;
                if (gb) pb = 0; else pa = 0;
                hit = (r.addr[20:14] == WB);
                resp_valid = 1; resp_b = gb; resp_rd = !r.wr;
                if (r.wr) begin
                    if (hit)
                        for (int b = 0; b < 4; b++)
                            if (r.be[b]) mm[r.addr[13:0]][8*b +: 8] = r.data[8*b +: 8];
                    resp_cycle = cyc + 1;
                end else begin
                    resp_data  = hit ? mm[r.addr[13:0]] : 32'h0;
                    resp_cycle = cyc + 1 + RD_LATENCY;
                end
                free_at = resp_cycle + 1;
            end
            if (a_rd_i || a_wr_i) begin
                if (pa) begin eovr[0] = 1; if (ecnt_a < 255) ecnt_a++; end
                pa = 1;
                sa = '{a_wr_i, a_addr_i, a_byte_en_i, a_data_i};
            end
            if (b_rd_i) begin
                if (pb) begin eovr[1] = 1; if (ecnt_b < 255) ecnt_b++; end
                pb = 1;
                sb = '{1'b0, b_addr_i, 4'h0, 32'h0};
            end
            if (resp_valid && resp_rd && resp_cycle == cyc + 1) begin
                if (resp_b) eq_b = resp_data; else eq_a = resp_data;
            end
        end
        cyc++;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        #1;
        if (reset_i) begin
            chk("rst_a_ready", 32'(a_ready_o), 32'd0);
            chk("rst_b_ready", 32'(b_ready_o), 32'd0);
            chk("rst_a_q", a_q_o, 32'd0);
            chk("rst_b_q", b_q_o, 32'd0);
            chk("rst_overrun", 32'(overrun_o), 32'd0);
        end else begin
            chk("a_ready", 32'(a_ready_o), 32'(resp_valid && resp_cycle == cyc && !resp_b));
            chk("b_ready", 32'(b_ready_o), 32'(resp_valid && resp_cycle == cyc && resp_b));
            chk("a_q", a_q_o, eq_a);
            chk("b_q", b_q_o, eq_b);
            chk("overrun", 32'(overrun_o), 32'(eovr));
`ifdef SOUND_RAM_OVERRUN_CNT_EN
            chk("a_ovr_cnt", 32'(a_overrun_cnt_o), 32'(ecnt_a));
            chk("b_ovr_cnt", 32'(b_overrun_cnt_o), 32'(ecnt_b));
`endif
        end
    end

    task automatic drive(input bit ard, input bit awr, input logic [20:0] aad,
                         input logic [3:0] be, input logic [31:0] ad,
                         input bit brd, input logic [20:0] bad);
        @(negedge clk);
        a_rd_i = ard; a_wr_i = awr; a_addr_i = aad; a_byte_en_i = be;
        a_data_i = ad; b_rd_i = brd; b_addr_i = bad;
    endtask

    task automatic tick(input int n);
        repeat (n) drive(1'b0, 1'b0, 21'd0, 4'd0, 32'd0, 1'b0, 21'd0);
    endtask

    task automatic a_write(input logic [20:0] ad, input logic [3:0] be, input logic [31:0] d);
        drive(1'b0, 1'b1, ad, be, d, 1'b0, 21'd0);
        tick(1);
    endtask

    int m, nb;
    logic [20:0] ra, rb;

    initial begin
        tick(3);
        #1;
        chk("reset_a_ready", 32'(a_ready_o), 32'd0);
        chk("reset_overrun", 32'(overrun_o), 32'd0);
        @(negedge clk) reset_i = 1'b0;
        tick(2);

        for (int i = 0; i < 32; i++) a_write(W(14'(i)), 4'hF, $urandom);

        // Byte-enable merge, then B read latency
        tick(10);
        a_write(W(14'h0010), 4'hF, 32'hAABBCCDD);
        a_write(W(14'h0010), 4'b0100, 32'h11111111);
        drive(1'b0, 1'b0, 21'd0, 4'd0, 32'd0, 1'b1, W(14'h0010));
        m = cyc;
        tick(2); #1;
        chk("d1_b_ready_early", 32'(b_ready_o), 32'd0);
        tick(1); #1;
        chk("d1_b_ready", 32'(b_ready_o), 32'd1);
        chk("d1_b_q", b_q_o, 32'hAA11CCDD);

        // Simultaneous reads: A first, then B first
        tick(10);
        drive(1'b1, 1'b0, W(14'h0010), 4'd0, 32'd0, 1'b1, W(14'h0010));
        tick(3); #1;
        chk("d2_a_ready_first", 32'(a_ready_o), 32'd1);
        chk("d2_a_q", a_q_o, 32'hAA11CCDD);
        tick(3); #1;
        chk("d2_b_ready_second", 32'(b_ready_o), 32'd1);
        tick(10);
        drive(1'b1, 1'b0, W(14'h0010), 4'd0, 32'd0, 1'b1, W(14'h0010));
        tick(3); #1;
        chk("d2_b_ready_first", 32'(b_ready_o), 32'd1);
        chk("d2_a_not_yet", 32'(a_ready_o), 32'd0);
        tick(3); #1;
        chk("d2_a_ready_second", 32'(a_ready_o), 32'd1);

        // B overrun while A's read is in flight
        tick(10);
        a_write(W(14'h0001), 4'hF, 32'h01010101);
        a_write(W(14'h0002), 4'hF, 32'h02020202);
        tick(10);
        drive(1'b1, 1'b0, W(14'h0010), 4'd0, 32'd0, 1'b0, 21'd0);
        m = cyc;
        drive(1'b0, 1'b0, 21'd0, 4'd0, 32'd0, 1'b1, W(14'h0001));
        drive(1'b0, 1'b0, 21'd0, 4'd0, 32'd0, 1'b1, W(14'h0002));
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1); #1;
            if (b_ready_o) nb++;
            if (cyc == m + 6) begin
                chk("d3_b_ready", 32'(b_ready_o), 32'd1);
                chk("d3_b_q", b_q_o, 32'h02020202);
            end
        end
        chk("d3_b_ready_count", 32'(nb), 32'd1);
        chk("d3_overrun", 32'(overrun_o), 32'h2);
`ifdef SOUND_RAM_OVERRUN_CNT_EN
        chk("d3_b_cnt", 32'(b_overrun_cnt_o), 32'd1);
`endif

        // Out-of-window accesses
        tick(10);
        drive(1'b0, 1'b0, 21'd0, 4'd0, 32'd0, 1'b1, {7'b0000101, 14'h0010});
        tick(3); #1;
        chk("d4_b_ready", 32'(b_ready_o), 32'd1);
        chk("d4_b_q_zero", b_q_o, 32'h0);
        a_write({7'b0000101, 14'h0010}, 4'hF, 32'hDEADBEEF);
        tick(5);
        drive(1'b0, 1'b0, 21'd0, 4'd0, 32'd0, 1'b1, W(14'h0010));
        tick(3); #1;
        chk("d4_mem_unchanged", b_q_o, 32'hAA11CCDD);

        // Reset during RD_WAIT
        tick(10);
        drive(1'b1, 1'b0, W(14'h0001), 4'd0, 32'd0, 1'b0, 21'd0);
        tick(1);
        @(negedge clk) reset_i = 1'b1;
        tick(1);
        #1;
        chk("d5_a_ready", 32'(a_ready_o), 32'd0);
        chk("d5_a_q", a_q_o, 32'd0);
        chk("d5_b_q", b_q_o, 32'd0);
        chk("d5_overrun", 32'(overrun_o), 32'd0);
        tick(1);
        @(negedge clk) reset_i = 1'b0;
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1); #1;
            if (a_ready_o) nb++;
        end
        chk("d5_no_ready", 32'(nb), 32'd0);
        drive(1'b0, 1'b0, 21'd0, 4'd0, 32'd0, 1'b1, W(14'h0001));
        tick(3); #1;
        chk("d5_mem_kept", b_q_o, 32'h01010101);

        // Overrun storm on A
        tick(10);
        for (int i = 0; i < 500; i++)
            drive(1'b1, 1'b0, W(14'($urandom_range(0, 31))), 4'd0, 32'd0, 1'b0, 21'd0);
        tick(10); #1;
        chk("d6_overrun", 32'(overrun_o), 32'h1);
`ifdef SOUND_RAM_OVERRUN_CNT_EN
        chk("d6_a_cnt_sat", 32'(a_overrun_cnt_o), 32'hFF);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                @(negedge clk) reset_i = 1'b1;
                tick(2);
                @(negedge clk) reset_i = 1'b0;
            end
            ra = ($urandom_range(0, 9) == 0) ? {7'($urandom_range(5, 127)), 14'($urandom_range(0, 31))}
                                             : W(14'($urandom_range(0, 31)));
            rb = ($urandom_range(0, 9) == 0) ? {7'($urandom_range(0, 3)), 14'($urandom_range(0, 31))}
                                             : W(14'($urandom_range(0, 31)));
            drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15, ra,
                  4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 99) < 25, rb);
        end
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
